// File: rtl/jericalla_pkg.sv
// Shared definitions for the JERICALLA instruction sequencer: word format and FSM states.
package jericalla_pkg;

    localparam int IW       = 17;
    localparam int EN_BIT   = 16;
    localparam int DIR1_MSB = 15;
    localparam int DIR1_LSB = 12;
    localparam int DIR2_MSB = 11;
    localparam int DIR2_LSB = 8;
    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 4;
    localparam int DIRR_MSB = 3;
    localparam int DIRR_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Assemble a datapath word from its fields.
    function automatic logic [IW-1:0] pack_instr(input logic en, input logic [3:0] d1,
                                                 input logic [3:0] d2, input logic [3:0] op,
                                                 input logic [3:0] dr);
        logic [IW-1:0] w;
        w = '0;
        w[EN_BIT]              = en;
        w[DIR1_MSB:DIR1_LSB]   = d1;
        w[DIR2_MSB:DIR2_LSB]   = d2;
        w[OP_MSB:OP_LSB]       = op;
        w[DIRR_MSB:DIRR_LSB]   = dr;
        return w;
    endfunction

endpackage

// File: rtl/jericalla_prog_mem.sv
// Program store: one synchronous write port, one asynchronous read port, contents not reset.
module jericalla_prog_mem
    import jericalla_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = IW,
    localparam int AW = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write on the accepting edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jericalla_seq.sv
// Instruction sequencer: loads a program, then issues one word per cycle to the datapath.
module jericalla_seq
    import jericalla_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IW = jericalla_pkg::IW,
    localparam int AW = $clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          halt_on_zf,
    input  logic          zf_in,
    output logic [IW-1:0] instr_out,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          zf_halt
);

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    seq_state_t    state, state_nxt;
    logic [AW:0]   len_q, len_sat;
    logic          hz_q;
    logic [AW-1:0] pc_nxt;
    logic [IW-1:0] rdata;
    logic          issue, start_ok, load_acc, last, zf_stop, term;

    assign load_ready = (state != RUN);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign load_acc   = load_valid && load_ready;

    jericalla_prog_mem #(.DEPTH(DEPTH), .WIDTH(IW)) u_mem (
        .clk   (clk),
        .we    (load_acc),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_nxt),
        .rdata (rdata)
    );

    // Next state, next pc and issue decision; memory is read at the next pc.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        issue     = 1'b0;
        len_sat   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
        start_ok  = start && (prog_len != '0) && (state != RUN);
        last      = ({1'b0, pc} == (len_q - 1'b1));
        zf_stop   = hz_q && zf_in && instr_valid;
        term      = (state == RUN) && instr_valid && (last || zf_stop);
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                    issue     = 1'b1;
                end
            end
            RUN: begin
                if (term) begin
                    state_nxt = DONE;
                end else begin
                    pc_nxt = pc + 1'b1;
                    issue  = 1'b1;
                end
            end
            DONE: begin
                // A start in the same cycle as a load goes to RUN, not IDLE.
                if (start_ok) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                    issue     = 1'b1;
                end else if (load_acc) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pc, output word and run-parameter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            len_q       <= '0;
            hz_q        <= 1'b0;
            zf_halt     <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_valid <= issue;
            instr_out   <= issue ? rdata : '0;
            if (start_ok) begin
                len_q   <= len_sat;
                hz_q    <= halt_on_zf;
                zf_halt <= 1'b0;
            end else if (term && zf_stop) begin
                zf_halt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jericalla_seq.sv
// Self-checking bench for jericalla_seq: table-driven runs, hand sequences, randomized runs.
module tb_jericalla_seq;
    import jericalla_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int NONE  = 99;

    logic          clk, rst_n;
    logic          load_valid, load_ready;
    logic [AW-1:0] load_addr;
    logic [IW-1:0] load_data;
    logic [AW:0]   prog_len;
    logic          start, halt_on_zf, zf_in;
    logic [IW-1:0] instr_out;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy, done, zf_halt;

    int n_assert = 0;
    int n_fail   = 0;
    logic [IW-1:0] mem_m [DEPTH];

    jericalla_seq #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .prog_len    (prog_len),
        .start       (start),
        .halt_on_zf  (halt_on_zf),
        .zf_in       (zf_in),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .zf_halt     (zf_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [IW-1:0] data);
        load_valid = 1'b1;
        load_addr  = addr[AW-1:0];
        load_data  = data;
        chk("load_ready_idle", 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0;
        mem_m[addr] = data;
    endtask

    // Start a run and follow it cycle by cycle against the memory model.
    task automatic run_prog(input int len, input bit halt, input int zfidx, input bit disturb,
                            output int issued, output bit zfh);
        bit prev_done;
        int cyc;
        prev_done  = done;
        prog_len   = len[AW:0];
        halt_on_zf = halt;
        start      = 1'b1;
        step();
        start      = 1'b0;
        prog_len   = '0;
        halt_on_zf = 1'b0;
        issued = 0;
        cyc    = 0;
        while (instr_valid && cyc < 40) begin
            chk("pc", 32'(pc), 32'(issued));
            chk("instr", 32'(instr_out), 32'(mem_m[issued]));
            chk("busy_run", 32'(busy), 32'd1);
            zf_in = (issued == zfidx);
            if (disturb && issued == 1) begin
                load_valid = 1'b1;
                load_addr  = 4'd3;
                load_data  = ~mem_m[3];
                start      = 1'b1;
                prog_len   = 5'd5;
                chk("load_ready_run", 32'(load_ready), 32'd0);
            end
            step();
            zf_in      = 1'b0;
            load_valid = 1'b0;
            start      = 1'b0;
            prog_len   = '0;
            issued++;
            cyc++;
        end
        if (cyc >= 40) chk("run_timeout", 32'(cyc), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("instr_after", 32'(instr_out), 32'd0);
        if (len == 0) chk("done_unchanged", 32'(done), 32'(prev_done));
        else          chk("done_after", 32'(done), 32'd1);
        zfh = zf_halt;
    endtask

    typedef struct {
        int len;
        bit halt;
        int zfidx;
        bit disturb;
        int exp_n;
        bit exp_zfh;
    } vec_t;

    initial begin
        vec_t tbl[10];
        int   n;
        bit   zh;

        rst_n = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
        prog_len = '0; start = 1'b0; halt_on_zf = 1'b0; zf_in = 1'b0;
        repeat (2) step();
        chk("rst_instr", 32'(instr_out), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_zfh", 32'(zf_halt), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd1);
        rst_n = 1'b1;
        step();

        tbl[0] = '{0,  0, NONE, 0, 0,  0};   // ignored start in IDLE
        tbl[1] = '{3,  0, NONE, 0, 3,  0};
        tbl[2] = '{4,  1, 1,    0, 2,  1};
        tbl[3] = '{5,  0, NONE, 1, 5,  0};   // load and start during RUN
        tbl[4] = '{20, 0, NONE, 0, 16, 0};   // saturates to DEPTH
        tbl[5] = '{20, 0, NONE, 0, 16, 0};   // rerun from DONE
        tbl[6] = '{16, 1, 15,   0, 16, 1};   // last word and ZF together
        tbl[7] = '{5,  0, 2,    0, 5,  0};   // ZF ignored without halt
        tbl[8] = '{1,  1, 0,    0, 1,  1};
        tbl[9] = '{0,  0, NONE, 0, 0,  0};   // ignored start in DONE

        run_prog(tbl[0].len, tbl[0].halt, tbl[0].zfidx, tbl[0].disturb, n, zh);
        chk("idle_len0_issued", 32'(n), 32'd0);
        chk("idle_len0_done", 32'(done), 32'd0);

        load_word(0, pack_instr(1'b1, 4'h2, 4'h3, 4'h4, 4'h0));
        load_word(1, pack_instr(1'b1, 4'h5, 4'h6, 4'h0, 4'h1));
        load_word(2, 17'h0_0000);
        for (int a = 3; a < DEPTH; a++) load_word(a, 17'($urandom));
        chk("word0", 32'(mem_m[0]), 32'h1_2340);
        chk("word1", 32'(mem_m[1]), 32'h1_5601);

        for (int i = 1; i < 10; i++) begin
            run_prog(tbl[i].len, tbl[i].halt, tbl[i].zfidx, tbl[i].disturb, n, zh);
            chk($sformatf("vec%0d_issued", i), 32'(n), 32'(tbl[i].exp_n));
            if (tbl[i].len != 0) chk($sformatf("vec%0d_zfh", i), 32'(zh), 32'(tbl[i].exp_zfh));
        end

        // A load in DONE returns to IDLE.
        load_word(4, 17'($urandom));
        chk("load_from_done_done", 32'(done), 32'd0);
        chk("load_from_done_busy", 32'(busy), 32'd0);

        // Reset in the middle of a run.
        prog_len = 5'd5; start = 1'b1;
        step();
        start = 1'b0; prog_len = '0;
        for (int c = 0; c < 10 && pc != 4'd2; c++) step();
        chk("pre_rst_pc", 32'(pc), 32'd2);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_instr", 32'(instr_out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pc", 32'(pc), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_done", 32'(done), 32'd0);
        chk("postrst_valid", 32'(instr_valid), 32'd0);
        chk("postrst_ready", 32'(load_ready), 32'd1);
        run_prog(5, 1'b0, NONE, 1'b0, n, zh);
        chk("postrst_issued", 32'(n), 32'd5);

        // Randomized runs against the rule-level model.
        for (int it = 0; it < 40; it++) begin
            int len, zfidx, eff, exp_n;
            bit halt, exp_z;
            if ($urandom_range(0, 2) == 0) load_word($urandom_range(0, DEPTH-1), 17'($urandom));
            len   = $urandom_range(0, 20);
            halt  = 1'($urandom_range(0, 1));
            zfidx = $urandom_range(0, 20);
            eff   = (len > DEPTH) ? DEPTH : len;
            exp_z = halt && (zfidx < eff);
            exp_n = exp_z ? zfidx + 1 : eff;
            run_prog(len, halt, zfidx, 1'b0, n, zh);
            chk($sformatf("rand%0d_issued", it), 32'(n), 32'(exp_n));
            if (len != 0) chk($sformatf("rand%0d_zfh", it), 32'(zh), 32'(exp_z));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
